// File: rtl/decode_buf_q.sv
// Decoded-bundle FIFO between fetch/decode and execute, with flush and an
// optional zero-latency bypass when the buffer is empty.
module decode_buf_q #(
  parameter int PAYLOAD_W = 244,
  parameter int DEPTH     = 4,
  parameter int BYPASS    = 0,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam bit BYP   = (BYPASS != 0);

  logic [PAYLOAD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_bypass;
  logic w_wr_en;
  logic w_rd_en;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // in_ready looks only at registered occupancy, so a full buffer refuses a
  // push even when the head is being consumed in the same cycle.
  assign in_ready  = !w_full;
  assign out_valid = !flush && (!w_empty || (BYP && in_valid));
  assign out_data  = (BYP && w_empty) ? in_data : r_mem[r_rd_ptr];

  assign w_push   = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;
  assign w_bypass = BYP && w_empty && w_push && w_pop;
  assign w_wr_en  = w_push && !w_bypass && !flush;
  assign w_rd_en  = w_pop && !w_bypass;

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;

  // NOTE: the payload array carries no reset; stale entries are unreachable
  // because out_valid is derived from the reset count, and leaving it
  // un-reset keeps the storage a plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    r_count <= CNT_W'(DEPTH));

  a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst)
    w_rd_en |-> !w_empty);

  a_in_stable: assert property (@(posedge clk) disable iff (!rst || flush)
    (in_valid && !in_ready) ##1 in_valid |-> $stable(in_data));

endmodule

// File: tb/tb_decode_buf_q.sv
// Directed bench for decode_buf_q: a non-bypass instance (queue reference)
// and a bypass instance (hand-computed expectations).
module tb_decode_buf_q;

  localparam int PW = 244;
  localparam int CW = 3;

  logic clk;
  logic rst;

  logic          flush0, in0_valid, in0_ready, out0_valid, out0_ready;
  logic [PW-1:0] in0_data, out0_data;
  logic [CW-1:0] count0;
  logic          full0, empty0;

  logic          flush1, in1_valid, in1_ready, out1_valid, out1_ready;
  logic [PW-1:0] in1_data, out1_data;
  logic [CW-1:0] count1;
  logic          full1, empty1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] q0 [$];

  decode_buf_q #(.PAYLOAD_W(PW), .DEPTH(4), .BYPASS(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in0_valid), .in_ready(in0_ready), .in_data(in0_data),
    .out_valid(out0_valid), .out_ready(out0_ready), .out_data(out0_data),
    .count(count0), .full(full0), .empty(empty0)
  );

  decode_buf_q #(.PAYLOAD_W(PW), .DEPTH(4), .BYPASS(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data),
    .count(count1), .full(full1), .empty(empty1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [PW-1:0] bundle(input logic [31:0] pc);
    return {pc[19:0] ^ 20'hA5A5A, {6{pc ^ 32'hDEAD_BEEF}}, pc};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the non-bypass instance, checked against the queue model.
  task automatic cyc0(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
    bit exp_valid;
    bit exp_ready;
    in0_valid  = v;
    in0_data   = bundle(pc);
    out0_ready = rdy;
    flush0     = fl;
    #1;
    exp_valid = (q0.size() != 0) && !fl;
    exp_ready = (q0.size() < 4);
    check("dut0 out_valid", out0_valid, exp_valid);
    check("dut0 in_ready", in0_ready, exp_ready);
    check("dut0 count", count0, q0.size());
    if (exp_valid) check("dut0 out_data", out0_data, q0[0]);
    tick();
    if (fl) begin
      q0.delete();
    end else begin
      if (exp_valid && rdy) void'(q0.pop_front());
      if (v && exp_ready) q0.push_back(bundle(pc));
    end
  endtask

  initial begin
    rst = 1'b0;
    {flush0, in0_valid, out0_ready} = '0;
    {flush1, in1_valid, out1_ready} = '0;
    in0_data = '0;
    in1_data = '0;
    #3;
    check("rst count", count0, 0);
    check("rst empty", empty0, 1);
    check("rst full", full0, 0);
    check("rst out_valid", out0_valid, 0);
    check("rst in_ready", in0_ready, 1);
    check("rst byp count", count1, 0);
    #20 rst = 1'b1;
    tick();

    // Fill and drain
    for (int i = 0; i < 4; i++) cyc0(1, 32'h100 + 32'(4 * i), 0, 0);
    in0_valid = 1'b0;
    #1;
    check("fill full", full0, 1);
    check("fill in_ready", in0_ready, 0);
    check("fill count", count0, 4);
    for (int i = 0; i < 4; i++) begin
      out0_ready = 1'b1;
      #1;
      check("drain out_valid", out0_valid, 1);
      check("drain pc", out0_data[31:0], 32'h100 + 32'(4 * i));
      tick();
      void'(q0.pop_front());
    end
    check("drain empty", empty0, 1);
    check("drain count", count0, 0);

    // Wrap-around: push 3, pop 3, push 4
    for (int i = 0; i < 3; i++) cyc0(1, 32'h400 + 32'(4 * i), 0, 0);
    for (int i = 0; i < 3; i++) cyc0(0, 32'h0, 1, 0);
    for (int i = 0; i < 4; i++) cyc0(1, 32'h500 + 32'(4 * i), 0, 0);

    // Full with pop: push refused, then accepted next cycle
    cyc0(1, 32'h600, 1, 0);
    check("fullpop count", count0, 3);
    check("fullpop in_ready", in0_ready, 1);
    cyc0(1, 32'h600, 0, 0);
    for (int i = 0; i < 4; i++) cyc0(0, 32'h0, 1, 0);
    check("wrap empty", empty0, 1);

    // Simultaneous push/pop at count 2
    cyc0(1, 32'h700, 0, 0);
    cyc0(1, 32'h704, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc0(1, 32'h708 + 32'(4 * i), 1, 0);
      check("steady count", count0, 2);
    end
    check("steady head pc", out0_data[31:0], 32'h728);

    // Flush at count 3 with a push presented
    cyc0(1, 32'h800, 1, 0);
    cyc0(1, 32'h804, 0, 0);
    check("preflush count", count0, 3);
    cyc0(1, 32'h808, 1, 1);
    in0_valid = 1'b0;
    #1;
    check("flush count", count0, 0);
    check("flush empty", empty0, 1);
    check("flush out_valid", out0_valid, 0);
    check("flush in_ready", in0_ready, 1);

    // Asynchronous reset mid-stream
    cyc0(1, 32'h900, 0, 0);
    cyc0(1, 32'h904, 0, 0);
    in0_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst count", count0, 0);
    check("arst empty", empty0, 1);
    check("arst full", full0, 0);
    check("arst out_valid", out0_valid, 0);
    check("arst in_ready", in0_ready, 1);
    q0.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick();
    cyc0(0, 32'h0, 1, 0);
    cyc0(1, 32'hA00, 0, 0);
    cyc0(0, 32'h0, 1, 0);
    check("post-rst empty", empty0, 1);

    // Bypass instance: empty pass-through
    in1_valid  = 1'b1;
    in1_data   = bundle(32'h200);
    out1_ready = 1'b1;
    #1;
    check("byp out_valid", out1_valid, 1);
    check("byp out_data", out1_data, bundle(32'h200));
    check("byp count", count1, 0);
    tick();
    in1_valid = 1'b0;
    #1;
    check("byp after count", count1, 0);
    check("byp after out_valid", out1_valid, 0);

    // Bypass instance: not consumed, so stored
    in1_valid  = 1'b1;
    out1_ready = 1'b0;
    #1;
    check("byp stall out_valid", out1_valid, 1);
    tick();
    in1_valid = 1'b0;
    #1;
    check("byp stored count", count1, 1);
    check("byp stored out_valid", out1_valid, 1);
    check("byp stored pc", out1_data[31:0], 32'h200);

    // Non-empty: storage head wins over in_data
    in1_valid  = 1'b1;
    in1_data   = bundle(32'h204);
    out1_ready = 1'b1;
    #1;
    check("byp head pc", out1_data[31:0], 32'h200);
    tick();
    in1_valid = 1'b0;
    #1;
    check("byp pp count", count1, 1);
    check("byp pp pc", out1_data[31:0], 32'h204);
    tick();
    check("byp drained", empty1, 1);

    // Flush blocks the bypass path
    in1_valid  = 1'b1;
    in1_data   = bundle(32'h208);
    flush1     = 1'b1;
    #1;
    check("byp flush out_valid", out1_valid, 0);
    tick();
    flush1    = 1'b0;
    in1_valid = 1'b0;
    #1;
    check("byp flush count", count1, 0);
    check("byp flush empty", empty1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_buf_q.md
Name: decode_buf_q

Overview:
- Parametrised FIFO between fetch/decode and execute.
- Each entry holds one packed decoded bundle: control word (20 b) + decoded instruction fields (192 b) + PC (32 b).
- Decouples fetch from execute stalls with valid/ready handshakes on both sides.
- Supports pipeline flush and an optional empty-bypass mode for zero-latency forwarding.

Parameters:
- PAYLOAD_W, 244, bit width of one bundle (ctrl 20 + instr 192 + pc 32).
- DEPTH, 4, number of entries; power of two, >= 2.
- BYPASS, 0, 1 = an empty buffer forwards in_data to out_data combinationally in the same cycle.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discard all entries (branch mispredict / jump redirect).
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  buffer can accept a bundle this cycle.
- in_data  in  PAYLOAD_W  upstream bundle.
- out_valid  out  1  head bundle valid.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  PAYLOAD_W  head bundle.
- count  out  CNT_W  entries currently stored (excludes a bypassed bundle).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst low, asynchronous): rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0, out_valid = 0, in_ready = 1.
  - out_data is don't-care; the bench checks it only when out_valid = 1.
  - Storage array is not reset.
- Transfers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both are evaluated at the rising edge of clk.
- in_ready = !full.
  - Depends only on registered state; there is no combinational path from out_ready to in_ready.
  - Consequence: a push is refused when full, even if the same cycle pops.
- out_valid:
  - BYPASS=0: out_valid = !empty.
  - BYPASS=1: out_valid = !empty | in_valid.
- out_data:
  - Storage entry at rd_ptr when !empty.
  - Otherwise (BYPASS=1 only) in_data.
- Bypass case (BYPASS=1, empty, push & pop in the same cycle): the bundle goes straight through and is not written. Pointers and count are unchanged.
- Latency: push to out_valid is 1 cycle (BYPASS=0) or 0 cycles (BYPASS=1 and empty).
- Pointer and count updates:
  - Push (not bypassed): write mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
  - Pop from storage: rd_ptr wraps modulo DEPTH.
  - Push and pop together (not bypassed): count unchanged; both pointers advance.
  - Push only: count + 1.
  - Pop only: count - 1.
- Flush (synchronous, highest priority):
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0.
  - A push and a pop presented in the flush cycle are both ignored; upstream treats that bundle as squashed.
  - out_valid is forced to 0 during the flush cycle, including any bypass path.
- Order is strict FIFO; bundles are never reordered or duplicated.
- Protocol assumptions (assertions):
  - in_data is stable while in_valid & !in_ready.
  - No pop when out_valid = 0.
  - count <= DEPTH at all times.
- Reset mid-operation: all state clears immediately. Previously stored bundles must never appear on out_data with out_valid = 1 after reset is released.

Test Plan:
- Fill/drain, DEPTH=4, BYPASS=0: push 4 bundles with pc 0x100/0x104/0x108/0x10C, out_ready=0 -> full=1, in_ready=0, count=4. Then out_ready=1 -> the four pcs emerge in order over 4 cycles; empty=1 after.
- Wrap-around: push 3, pop 3, push 4 -> pointers wrap past index 3; output order matches input order with no gaps; count never exceeds 4.
- Simultaneous push/pop at count=2 for 10 cycles -> count stays 2; each output equals the input from 2 pops earlier.
- Full with pop: count=4, in_valid=1, out_ready=1 -> pop occurs, push refused (in_ready=0); next cycle count=3, in_ready=1.
- Bypass, BYPASS=1: empty, in_valid=1 with pc 0x200, out_ready=1 -> out_valid=1 and out_data pc=0x200 in the same cycle; count stays 0. Same stimulus with out_ready=0 -> entry stored, count=1.
- Flush/reset: count=3, assert flush with in_valid=1 -> next cycle count=0, empty=1, out_valid=0, in_ready=1. Pulse rst low mid-stream -> outputs take reset values immediately, without waiting for a clock edge.
